// File: rtl/flop_compare_seq.sv
// Stimulus/clock sequencer for flop equivalence benches: strobes stimulus, drives a
// flop-generated DUT clock well clear of stimulus changes, and tallies per-check results.
module flop_compare_seq #(
  parameter int NCHK   = 4,
  parameter int CW     = 16,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [CW-1:0]   num_iters,
  input  logic [NCHK-1:0] cfg_mask,
  input  logic [NCHK-1:0] ok,
  output logic            stim_load,
  output logic            dut_clk,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            aborted,
  output logic [CW-1:0]   fail_count,
  output logic [CW-1:0]   first_fail_iter,
  output logic [NCHK-1:0] first_fail_vec
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_RISE, S_CHECK, S_FALL, S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_num_iters;
  logic [CW-1:0]   r_iter;
  logic [CW-1:0]   r_fail_count;
  logic [CW-1:0]   r_first_fail_iter;
  logic [CW-1:0]   w_iter_inc;
  logic [NCHK-1:0] r_mask;
  logic [NCHK-1:0] r_first_fail_vec;
  logic [NCHK-1:0] w_ok_strict;
  logic [NCHK-1:0] w_fail_vec;
  logic [SW-1:0]   r_settle_cnt;
  logic            r_dut_clk;
  logic            r_pass;
  logic            r_aborted;
  logic            w_abort_act;

  // A check passes only on a solid 1; X or Z from a broken pair must read as a failure.
  always_comb begin
    w_ok_strict = '0;
    for (int i = 0; i < NCHK; i++) w_ok_strict[i] = (ok[i] === 1'b1);
  end

  assign w_fail_vec  = r_mask & ~w_ok_strict;
  assign w_iter_inc  = r_iter + CW'(1);
  assign w_abort_act = abort && (r_state inside {S_LOAD, S_SETTLE, S_RISE, S_CHECK, S_FALL});

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_next = (num_iters == '0) ? S_DONE : S_LOAD;
      S_LOAD:   w_next = w_abort_act ? S_FALL : S_SETTLE;
      S_SETTLE: begin
        if (w_abort_act)                      w_next = S_FALL;
        else if (r_settle_cnt == SETTLE_LAST) w_next = S_RISE;
      end
      S_RISE:   w_next = w_abort_act ? S_FALL : S_CHECK;
      S_CHECK:  w_next = S_FALL;
      S_FALL:   w_next = (w_abort_act || r_aborted || w_iter_inc == r_num_iters) ? S_DONE : S_LOAD;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state           <= S_IDLE;
      r_dut_clk         <= 1'b0;
      r_num_iters       <= '0;
      r_mask            <= '0;
      r_iter            <= '0;
      r_settle_cnt      <= '0;
      r_fail_count      <= '0;
      r_first_fail_iter <= '0;
      r_first_fail_vec  <= '0;
      r_pass            <= 1'b0;
      r_aborted         <= 1'b0;
    end else begin
      r_state   <= w_next;
      // The DUT clock comes straight from a flop so it is glitch-free.
      r_dut_clk <= (w_next == S_RISE) || (w_next == S_CHECK);
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_num_iters       <= num_iters;
            r_mask            <= cfg_mask;
            r_iter            <= '0;
            r_fail_count      <= '0;
            r_first_fail_iter <= '0;
            r_first_fail_vec  <= '0;
            r_aborted         <= 1'b0;
            r_pass            <= (num_iters == '0);
          end
        end
        S_LOAD: begin
          r_settle_cnt <= '0;
          if (w_abort_act) r_aborted <= 1'b1;
        end
        S_SETTLE: begin
          r_settle_cnt <= r_settle_cnt + SW'(1);
          if (w_abort_act) r_aborted <= 1'b1;
        end
        S_RISE: if (w_abort_act) r_aborted <= 1'b1;
        S_CHECK: begin
          if (w_abort_act) begin
            r_aborted <= 1'b1;
          end else if (w_fail_vec != '0) begin
            r_fail_count <= r_fail_count + CW'(1);
            if (r_fail_count == '0) begin
              r_first_fail_iter <= r_iter;
              r_first_fail_vec  <= w_fail_vec;
            end
          end
        end
        S_FALL: begin
          r_iter <= w_iter_inc;
          if (w_abort_act) r_aborted <= 1'b1;
          if (w_next == S_DONE) r_pass <= (r_fail_count == '0) && !r_aborted && !w_abort_act;
        end
        default: ;
      endcase
    end
  end

  assign stim_load       = (r_state == S_LOAD);
  assign dut_clk         = r_dut_clk;
  assign busy            = (r_state != S_IDLE);
  assign done            = (r_state == S_DONE);
  assign pass            = r_pass;
  assign aborted         = r_aborted;
  assign fail_count      = r_fail_count;
  assign first_fail_iter = r_first_fail_iter;
  assign first_fail_vec  = r_first_fail_vec;

endmodule

// File: tb/tb_flop_compare_seq.sv
// Scoreboard bench for flop_compare_seq: expected run results come from a cycle-level
// timing formula and per-iteration pass/fail arithmetic; a monitor checks them on done.
module tb_flop_compare_seq;
  localparam int NCHK   = 4;
  localparam int CW     = 16;
  localparam int SETTLE = 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [CW-1:0]   num_iters = '0;
  logic [NCHK-1:0] cfg_mask = '0;
  logic [NCHK-1:0] ok = '1;
  logic            stim_load, dut_clk, busy, done, pass, aborted;
  logic [CW-1:0]   fail_count, first_fail_iter;
  logic [NCHK-1:0] first_fail_vec;

  typedef struct packed {
    int              done_cyc;
    int              loads;
    logic [CW-1:0]   fc;
    logic [CW-1:0]   ffi;
    logic [NCHK-1:0] ffv;
    logic            pass_e;
    logic            abrt;
  } exp_t;

  exp_t            exp_q[$];
  logic [NCHK-1:0] ok_tbl[16];
  int              checks = 0;
  int              failures = 0;
  int              cyc = 0;
  int              ld_idx = 0;
  int              load_cnt = 0;
  bit              wf_active = 1'b0;
  int              wf_base = 0;
  int              wf_n = 0;

  flop_compare_seq #(.NCHK(NCHK), .CW(CW), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .num_iters(num_iters), .cfg_mask(cfg_mask), .ok(ok),
    .stim_load(stim_load), .dut_clk(dut_clk), .busy(busy), .done(done),
    .pass(pass), .aborted(aborted), .fail_count(fail_count),
    .first_fail_iter(first_fail_iter), .first_fail_vec(first_fail_vec)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stimulus generator: presents the next ok vector each time it is told to advance.
  always @(negedge clk) begin
    if (stim_load === 1'b1) begin
      ok = (ld_idx < 16) ? ok_tbl[ld_idx] : '1;
      ld_idx++;
      load_cnt++;
    end
  end

  // Monitor: pop one expected result per done pulse.
  always @(negedge clk) begin : mon
    exp_t e;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no run pending (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        check("done_cycle", 64'(cyc), 64'(e.done_cyc));
        check("stim_load_count", 64'(load_cnt), 64'(e.loads));
        check("fail_count", 64'(fail_count), 64'(e.fc));
        check("first_fail_iter", 64'(first_fail_iter), 64'(e.ffi));
        check("first_fail_vec", 64'(first_fail_vec), 64'(e.ffv));
        check("pass", 64'(pass), 64'(e.pass_e));
        check("aborted", 64'(aborted), 64'(e.abrt));
      end
    end
  end

  // Waveform checker for uninterrupted runs: every period is LOAD, SETTLE, RISE, CHECK, FALL.
  always @(negedge clk) begin : wf
    int         rel;
    logic [3:0] expw;
    if (wf_active) begin
      rel     = cyc - wf_base;
      expw[3] = (rel >= 1) && (rel <= 5 * wf_n - 4) && (rel % 5 == 1);
      expw[2] = (rel >= 1) && (rel <= 5 * wf_n) && ((rel % 5 == 3) || (rel % 5 == 4));
      expw[1] = (rel >= 1) && (rel <= 5 * wf_n + 1);
      expw[0] = (rel == 5 * wf_n + 1);
      check($sformatf("wave{load,dclk,busy,done} rel=%0d", rel),
            64'({stim_load, dut_clk, busy, done}), 64'(expw));
    end
  end

  function automatic int done_rel_of(input int n, input int abort_rel);
    if (abort_rel < 0) return 5 * n + 1;
    return (abort_rel % 5 == 0) ? abort_rel + 1 : abort_rel + 2;
  endfunction

  // Reference: iteration i loads at rel 1+5i and samples at rel 4+5i; an abort in cycle a
  // cancels every sample not yet taken before a.
  function automatic exp_t model(input int n, input logic [NCHK-1:0] mask,
                                 input int abort_rel, input int base);
    exp_t            e;
    logic [NCHK-1:0] fv;
    e = '0;
    for (int i = 0; i < n; i++) begin
      if (abort_rel < 0 || 1 + 5 * i <= abort_rel) e.loads++;
      if (abort_rel < 0 || 4 + 5 * i < abort_rel) begin
        for (int b = 0; b < NCHK; b++) fv[b] = mask[b] && !(ok_tbl[i][b] === 1'b1);
        if (fv != '0) begin
          if (e.fc == '0) begin
            e.ffi = CW'(i);
            e.ffv = fv;
          end
          e.fc++;
        end
      end
    end
    e.abrt     = (abort_rel >= 0);
    e.pass_e   = (e.fc == '0) && !e.abrt;
    e.done_cyc = base + done_rel_of(n, abort_rel);
    return e;
  endfunction

  task automatic run_one(input int n, input logic [NCHK-1:0] mask,
                         input int abort_rel, input int busy_start_rel);
    int base;
    bit got;
    @(negedge clk); #1;
    base      = cyc;
    ld_idx    = 0;
    load_cnt  = 0;
    exp_q.push_back(model(n, mask, abort_rel, base));
    wf_base   = base;
    wf_n      = n;
    wf_active = (abort_rel < 0);
    start     = 1'b1;
    num_iters = CW'(n);
    cfg_mask  = mask;
    got       = 1'b0;
    for (int rel = 1; rel <= 5 * n + 30; rel++) begin
      @(negedge clk); #1;
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      start     = (rel == busy_start_rel);
      abort     = (rel == abort_rel);
      num_iters = CW'($urandom);
      cfg_mask  = NCHK'($urandom);
    end
    start = 1'b0;
    abort = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done expected done for n=%0d", n);
    end
    @(negedge clk); #1;
    wf_active = 1'b0;
  endtask

  task automatic fill_ok(input logic [NCHK-1:0] v);
    for (int i = 0; i < 16; i++) ok_tbl[i] = v;
  endtask

  initial begin
    fill_ok('1);
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", 64'({stim_load, dut_clk, busy, done, pass, aborted,
                               fail_count, first_fail_iter, first_fail_vec}), 64'(0));
    reset = 1'b0;

    run_one(3, 4'b1111, -1, -1);
    ok_tbl[1] = 4'b1011;
    run_one(3, 4'b1111, -1, -1);
    fill_ok(4'b1011);
    run_one(4, 4'b1011, -1, -1);
    fill_ok(4'b111x);
    run_one(2, 4'b0001, -1, -1);
    fill_ok('1);
    ok_tbl[0] = 4'b0110;
    run_one(3, 4'b1111, 8, 5);
    run_one(0, 4'b1111, -1, -1);

    // Reset in the middle of SETTLE, then a clean run.
    @(negedge clk); #1;
    ld_idx    = 0;
    start     = 1'b1;
    num_iters = CW'(3);
    cfg_mask  = '1;
    @(negedge clk); #1;
    start = 1'b0;
    @(negedge clk); #1;
    check("busy_before_reset", 64'(busy), 64'(1));
    reset = 1'b1;
    #1;
    check("reset_mid_settle", 64'({stim_load, dut_clk, busy, done, pass, aborted,
                                  fail_count, first_fail_iter, first_fail_vec}), 64'(0));
    @(negedge clk); #1;
    reset = 1'b0;
    fill_ok('1);
    ok_tbl[2] = 4'b0111;
    run_one(3, 4'b1111, -1, -1);

    for (int r = 0; r < 24; r++) begin
      int              n;
      int              ar;
      int              bs;
      logic [NCHK-1:0] m;
      n = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
      m = NCHK'($urandom);
      for (int i = 0; i < 16; i++)
        ok_tbl[i] = ($urandom_range(0, 2) == 0) ? NCHK'($urandom) : '1;
      ar = (n > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5 * n)) : -1;
      bs = -1;
      if (done_rel_of(n, ar) > 1 && $urandom_range(0, 2) == 0)
        bs = int'($urandom_range(1, done_rel_of(n, ar) - 1));
      run_one(n, m, ar, bs);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
